// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and
// the result flag bundle.
package alu_seq_pkg;

    localparam int OP_W = 4;

    // Codes 12..15 are illegal; the first and last illegal codes are named so
    // the legal/illegal boundary is visible wherever opcodes are decoded.
    typedef enum logic [OP_W-1:0] {
        OP_ADD       = 4'd0,
        OP_SUB       = 4'd1,
        OP_AND       = 4'd2,
        OP_OR        = 4'd3,
        OP_XOR       = 4'd4,
        OP_NOT       = 4'd5,
        OP_SHL       = 4'd6,
        OP_SHR       = 4'd7,
        OP_SRA       = 4'd8,
        OP_ROL       = 4'd9,
        OP_ROR       = 4'd10,
        OP_MUL       = 4'd11,
        OP_ILL_FIRST = 4'd12,
        OP_ILL_13    = 4'd13,
        OP_ILL_14    = 4'd14,
        OP_ILL_LAST  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles
// after start. 'done' is high during the cycle of the final iteration and
// 'product' already shows the finished value then, so the caller can load it
// on the same edge the last iteration retires. The product is held afterwards.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (cnt_reg == LAST_ITER);
    assign product = done ? acc_next : acc_reg;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops go straight from the combinational
// datapath into the output register; MUL runs in the shift-add multiplier
// while the FSM blocks new input until its result has been loaded.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    localparam logic [WIDTH-1:0] W_CONST   = WIDTH'(WIDTH);
    localparam logic [SHW:0]     W_ROT     = (SHW + 1)'(WIDTH);

    state_e             state_reg, state_next;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   y_reg, y_hi_reg;
    flags_t             flags_reg;

    logic               accept, out_free, mul_start, mul_load;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    flags_t             mul_flags;

    logic [WIDTH-1:0]   alu_y;
    flags_t             alu_flags;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic               big_shift;
    logic [SHW-1:0]     rot_amt;
    logic [SHW:0]       rot_inv;

    // The output register can take a new value if empty or being drained now.
    assign out_free  = !out_valid_reg || out_ready;
    assign in_ready  = !rst && (state_reg == IDLE) && !mul_busy && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e'(op) == OP_MUL);
    assign mul_load  = ((state_reg == MUL) && mul_done && out_free) ||
                       ((state_reg == WAIT) && out_ready);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shift/rotate helpers; a rotate by 0 makes the complementary shift
    // amount WIDTH, which shifts everything out and contributes nothing.
    assign sum_ext   = {1'b0, a} + {1'b0, b};
    assign diff_ext  = {1'b0, a} - {1'b0, b};
    assign big_shift = (b >= W_CONST);
    assign rot_amt   = SHW'(b % W_CONST);
    assign rot_inv   = W_ROT - {1'b0, rot_amt};

    // Single-cycle datapath and its flags.
    always_comb begin
        alu_y     = '0;
        alu_flags = '0;
        case (op_e'(op))
            OP_ADD: begin
                alu_y           = sum_ext[WIDTH-1:0];
                alu_flags.carry = sum_ext[WIDTH];
                alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y           = diff_ext[WIDTH-1:0];
                alu_flags.carry = diff_ext[WIDTH];
                alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_NOT: alu_y = ~a;
            OP_SHL: alu_y = big_shift ? '0 : (a << b);
            OP_SHR: alu_y = big_shift ? '0 : (a >> b);
            OP_SRA: alu_y = big_shift ? {WIDTH{a[WIDTH-1]}}
                                      : $unsigned($signed(a) >>> b);
            OP_ROL: alu_y = (a << rot_amt) | (a >> rot_inv);
            OP_ROR: alu_y = (a >> rot_amt) | (a << rot_inv);
            OP_MUL: alu_y = '0;
            default: alu_flags.err = 1'b1;
        endcase
        alu_flags.zero = (alu_y == '0);
        alu_flags.neg  = alu_y[WIDTH-1];
    end

    // Flags for a finished multiply judge the full double-width product.
    always_comb begin
        mul_flags       = '0;
        mul_flags.carry = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_flags.zero  = (mul_product == '0);
        mul_flags.neg   = mul_product[2*WIDTH-1];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: MUL parks in WAIT if its result cannot be loaded yet.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (mul_start) state_next = MUL;
            MUL:  if (mul_done)  state_next = out_free ? IDLE : WAIT;
            WAIT: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register: loads new results, otherwise holds until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            y_hi_reg      <= '0;
            flags_reg     <= '0;
        end else if (accept && !mul_start) begin
            out_valid_reg <= 1'b1;
            y_reg         <= alu_y;
            y_hi_reg      <= '0;
            flags_reg     <= alu_flags;
        end else if (mul_load) begin
            out_valid_reg <= 1'b1;
            y_reg         <= mul_product[WIDTH-1:0];
            y_hi_reg      <= mul_product[2*WIDTH-1:WIDTH];
            flags_reg     <= mul_flags;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign y_hi      = y_hi_reg;
    assign carry     = flags_reg.carry;
    assign zero      = flags_reg.zero;
    assign neg       = flags_reg.neg;
    assign ovf       = flags_reg.ovf;
    assign err       = flags_reg.err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed corner cases, then a
// randomized run scored against an arithmetic reference model.
module tb_alu_seq;

    logic       clk, rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, y, y_hi;
    logic [3:0] op;
    logic       carry, zero, neg, ovf, err;
    logic [20:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err)
    );

    assign obs = {y_hi, y, carry, zero, neg, ovf, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {y_hi, y, carry, zero, neg, ovf, err} from plain integer maths.
    function automatic logic [20:0] model(input int o, input int aa, input int bb);
        int r, hi, s, sa, sb, k;
        bit c, z, n, v, e;
        r = 0; hi = 0; c = 0; v = 0; e = 0;
        sa = (aa >= 128) ? aa - 256 : aa;
        sb = (bb >= 128) ? bb - 256 : bb;
        k  = bb % 8;
        case (o)
            0: begin s = aa + bb; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin s = aa - bb; r = (s + 256) % 256; c = (aa < bb); v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = aa & bb;
            3: r = aa | bb;
            4: r = aa ^ bb;
            5: r = 255 - aa;
            6: r = (bb >= 8) ? 0 : (aa * (1 << bb)) % 256;
            7: r = (bb >= 8) ? 0 : aa / (1 << bb);
            8: begin
                if (bb >= 8) r = (sa < 0) ? 255 : 0;
                else begin s = sa >>> bb; r = (s + 256) % 256; end
            end
            9:  r = ((aa << k) | (aa >> (8 - k))) % 256;
            10: r = ((aa >> k) | (aa << (8 - k))) % 256;
            11: begin s = aa * bb; r = s % 256; hi = s / 256; c = (hi != 0); end
            default: e = 1;
        endcase
        z = (o == 11) ? (aa * bb == 0) : (r == 0);
        n = (o == 11) ? (hi >= 128) : (r >= 128);
        return {hi[7:0], r[7:0], c, z, n, v, e};
    endfunction

    // Issue one op with out_ready=1 and check latency, result and busy in_ready.
    task automatic run_op(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input int lat, input logic [7:0] exp_y);
        logic [20:0] exp;
        int cyc;
        exp = model(int'(o), int'(aa), int'(bb));
        in_valid = 1'b1; op = o; a = aa; b = bb; out_ready = 1'b1;
        #1;
        check("in_ready_offer", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, lat);
        check("result", obs, exp);
        check("y_table", y, exp_y);
        $display("op=%0d a=%02h b=%02h -> y_hi=%02h y=%02h c=%0b z=%0b n=%0b v=%0b e=%0b lat=%0d",
                 o, aa, bb, y_hi, y, carry, zero, neg, ovf, err, cyc);
        @(posedge clk); #1;
        check("valid_drop", out_valid, 0);
    endtask

    logic [20:0] q[$];
    logic [20:0] held, exp_m;
    logic        stall_prev;
    int          idle_cnt, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", obs, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed corner cases.
        run_op(4'd0,  8'hFF, 8'h01, 1, 8'h00);
        run_op(4'd1,  8'h80, 8'h01, 1, 8'h7F);
        run_op(4'd1,  8'h01, 8'h02, 1, 8'hFF);
        run_op(4'd8,  8'h90, 8'd9,  1, 8'hFF);
        run_op(4'd9,  8'h81, 8'd9,  1, 8'h03);
        run_op(4'd6,  8'h01, 8'd8,  1, 8'h00);
        run_op(4'd12, 8'h55, 8'h03, 1, 8'h00);
        run_op(4'd10, 8'h81, 8'd1,  1, 8'hC0);
        run_op(4'd5,  8'h0F, 8'h00, 1, 8'hF0);
        run_op(4'd7,  8'h80, 8'd7,  1, 8'h01);
        run_op(4'd11, 8'hFF, 8'hFF, 9, 8'h01);

        // MUL finishing into a stalled consumer: result must hold.
        exp_m = model(11, 8'hFF, 8'hFF);
        in_valid = 1'b1; op = 4'd11; a = 8'hFF; b = 8'hFF; out_ready = 1'b0;
        #1;
        check("mulbp_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mulbp_latency", cyc, 9);
        repeat (3) begin
            check("mulbp_hold", obs, exp_m);
            check("mulbp_valid", out_valid, 1);
            check("mulbp_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mulbp_drop", out_valid, 0);
        $display("mul under backpressure held y_hi=fe y=01 for 3 cycles");

        // Two back-to-back ADDs into a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        check("bp_first_valid", out_valid, 1);
        a = 8'h05; b = 8'h06;
        repeat (3) begin
            check("bp_in_ready_low", in_ready, 0);
            check("bp_y_stable", y, 8'h30);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_y", y, 8'h0B);
        @(posedge clk); #1;
        check("bp_drain", out_valid, 0);
        $display("backpressure: second add accepted on first handshake edge");

        // Reset four cycles into a MUL aborts it.
        in_valid = 1'b1; op = 4'd11; a = 8'h12; b = 8'h34; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_outputs", obs, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        $display("reset during mul: no result produced");

        // Randomized traffic scored against the reference model.
        stall_prev = 1'b0; idle_cnt = 0; held = '0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = ($urandom_range(0, 9) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
            a         = 8'($urandom);
            b         = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall_prev) begin
                check("rand_hold_valid", out_valid, 1);
                check("rand_hold_data", obs, held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_unexpected", 1, 0);
                else check("rand_result", obs, q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(op), int'(a), int'(b)));
                $display("rand op=%0d a=%02h b=%02h accepted", op, a, b);
            end
            stall_prev = out_valid && !out_ready;
            held = obs;
            if (q.size() != 0 && !out_valid) idle_cnt++;
            else idle_cnt = 0;
            if (idle_cnt > 20) begin
                check("rand_timeout", idle_cnt, 0);
                idle_cnt = 0;
                q.delete();
            end
            @(posedge clk); #1;
        end

        // Drain whatever is still in flight.
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid && q.size() != 0) check("drain_result", obs, q.pop_front());
            @(posedge clk); #1;
        end
        check("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU: the next generation of the team's 4-bit combinational ALU. It takes WIDTH-bit operands and an opcode over a valid/ready interface, returns a registered result with carry, zero, negative and overflow flags, and adds arithmetic shift, rotates and a multi-cycle unsigned multiply. It sits between an operand-issue stage and a result-consuming stage that may apply backpressure.

## Interface
- WIDTH, 8, operand and result width; must be ≥ 4.
- SHW, $clog2(WIDTH), derived; width of the rotate-amount field.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- a, b  in  WIDTH  operands, unsigned unless stated.
- op  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result (low half for MUL).
- y_hi  out  WIDTH  MUL high half; 0 for all other ops.
- carry, zero, neg, ovf, err  out  1 each  result flags.

## Operation
- Opcodes (0–11): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR, 8 SRA, 9 ROL, 10 ROR, 11 MUL. Codes 12–15 are illegal.
- ADD: {carry,y}=a+b. ovf is signed overflow.
- SUB: {carry,y}=a−b, so carry=1 on borrow (a<b). ovf is signed overflow.
- SHL / SHR / SRA shift by the full unsigned b.
  - If b ≥ WIDTH: SHL and SHR give 0; SRA gives all copies of a[WIDTH-1].
- ROL / ROR rotate by b mod WIDTH, using b[SHW-1:0] when WIDTH is a power of two.
- MUL: unsigned shift-add over WIDTH iterations. {y_hi,y}=a*b; carry=(y_hi≠0).
- Illegal opcode: y=0, y_hi=0, err=1, zero=1, all other flags 0.
- Flags:
  - zero=(y==0). For MUL, zero=({y_hi,y}==0).
  - neg=y[WIDTH-1]. For MUL, neg=y_hi[WIDTH-1].
  - carry and ovf are 0 for logic, shift and rotate ops.
  - err is 0 for legal ops.
- Output register: y, y_hi and all flags hold stable while out_valid && !out_ready.
- FSM states:
  - IDLE→MUL on an accepted MUL.
  - MUL→IDLE after WIDTH iterations if the output register is free (!out_valid || out_ready). Otherwise MUL→WAIT.
  - WAIT→IDLE when out_ready=1; the result loads on that edge.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Operands are captured on the accept edge; later changes to a, b and op have no effect.

## Timing
- Reset: out_valid=0, y=0, y_hi=0, all flags 0, state=IDLE. in_ready=0 while rst=1 and 1 in the first cycle after release.
- Reset during MUL or WAIT aborts the operation. No result is produced.
- Single-cycle ops: out_valid rises the cycle after accept (latency 1). Full throughput of one op per cycle when out_ready=1.
- MUL: out_valid rises WIDTH+1 cycles after accept when not stalled. in_ready=0 from the cycle after accept until the result loads.
- Simultaneous out_ready and accept: the old result is consumed and the new result loads on the same edge, with no bubble.
- out_valid drops the cycle after a handshake when nothing new was accepted.

## Structure
- Package alu_seq_pkg:
  - op_e enum for the 16 opcodes, including the illegal range boundary.
  - state_e {IDLE, MUL, WAIT}.
  - Flag-bundle struct.
- Sub-module alu_mul_seq (parameter WIDTH): start/busy/done shift-add multiplier producing a 2·WIDTH product.
- The top level keeps the combinational single-cycle datapath, FSM and output register.

## Test plan
All cases use WIDTH=8.
- ADD 0xFF+0x01 → y=0x00, carry=1, zero=1, ovf=0, out_valid 1 cycle after accept.
- SUB 0x80−0x01 → y=0x7F, ovf=1, carry=0. SUB 0x01−0x02 → y=0xFF, carry=1, neg=1.
- SRA 0x90 by 9 → 0xFF, neg=1. ROL 0x81 by 9 → 0x03. SHL 0x01 by 8 → 0x00, zero=1. Opcode 12 → y=0, err=1.
- MUL 0xFF×0xFF → y_hi=0xFE, y=0x01, carry=1, out_valid 9 cycles after accept, in_ready low throughout. Hold out_ready=0 at completion → FSM in WAIT, result loads when out_ready rises.
- Backpressure: out_ready=0 and two ADDs offered back-to-back → second stalled (in_ready=0), y stable. Set out_ready=1 → second accepted on the same edge as the first's handshake.
- Assert rst 4 cycles into a MUL → no out_valid afterward; all outputs 0; in_ready=1 the cycle after rst deasserts.
